// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency results wait in a FIFO.
// Optional same-cycle bypass of long-latency results into an idle port: define RF_WB_BYPASS_EN.
module rf_wb_arbiter #(
   parameter int DEPTH    = 2,
   parameter int MAX_WAIT = 4,
   parameter int CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             pipe_we_i,
   input  logic [4:0]       pipe_waddr_i,
   input  logic [31:0]      pipe_wdata_i,
   input  logic             ll_valid_i,
   output logic             ll_ready_o,
   input  logic [4:0]       ll_waddr_i,
   input  logic [31:0]      ll_wdata_i,
   output logic             rf_we_o,
   output logic [4:0]       rf_waddr_o,
   output logic [31:0]      rf_wdata_o,
   output logic             pipe_stall_o,
   output logic [31:0]      pending_mask_o,
   output logic [CNT_W-1:0] fifo_count_o
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [4:0]        addr_q [DEPTH];
   logic [31:0]       data_q [DEPTH];

   logic pipe_req;
   logic nonempty;
   logic accept;
   logic stall;
   logic deq;
   logic enq;
   logic bypass;

   assign pipe_req   = pipe_we_i && (pipe_waddr_i != 5'd0);
   assign nonempty   = (count_q != '0);
   assign ll_ready_o = (count_q < CNT_W'(DEPTH));
   assign accept     = ll_valid_i && ll_ready_o;
   assign stall      = nonempty && (wait_q == WAIT_W'(MAX_WAIT));
   assign deq        = stall || (nonempty && !pipe_req);

`ifdef RF_WB_BYPASS_EN
   assign bypass = !nonempty && !pipe_req && accept && (ll_waddr_i != 5'd0);
`else
   assign bypass = 1'b0;
`endif

   // x0 results are consumed by the handshake but never stored
   assign enq = accept && (ll_waddr_i != 5'd0) && !bypass;

   assign pipe_stall_o = stall && pipe_req;
   assign fifo_count_o = count_q;

   always_comb begin
      rf_we_o    = 1'b0;
      rf_waddr_o = '0;
      rf_wdata_o = '0;
      if (deq) begin
         rf_we_o    = 1'b1;
         rf_waddr_o = addr_q[rd_ptr_q];
         rf_wdata_o = data_q[rd_ptr_q];
      end else if (pipe_req) begin
         rf_we_o    = 1'b1;
         rf_waddr_o = pipe_waddr_i;
         rf_wdata_o = pipe_wdata_i;
      end else if (bypass) begin
         rf_we_o    = 1'b1;
         rf_waddr_o = ll_waddr_i;
         rf_wdata_o = ll_wdata_i;
      end
   end

   always_comb begin
      pending_mask_o = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (valid_q[i]) pending_mask_o[addr_q[i]] = 1'b1;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      valid_d  = valid_q;
      if (deq) begin
         rd_ptr_d          = rd_ptr_q + 1'b1;
         valid_d[rd_ptr_q] = 1'b0;
      end
      if (enq) begin
         wr_ptr_d          = wr_ptr_q + 1'b1;
         valid_d[wr_ptr_q] = 1'b1;
      end
      case ({enq, deq})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // A non-empty FIFO that is not dequeued is necessarily blocked by pipe_req
   always_comb begin
      wait_d = wait_q;
      if (!nonempty || deq) begin
         wait_d = '0;
      end else if (wait_q != WAIT_W'(MAX_WAIT)) begin
         wait_d = wait_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         wait_q   <= '0;
         valid_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         wait_q   <= wait_d;
         valid_q  <= valid_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq) begin
         addr_q[wr_ptr_q] <= ll_waddr_i;
         data_q[wr_ptr_q] <= ll_wdata_i;
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: queue-based reference model checked every cycle, directed scenarios plus random traffic.
module tb_rf_wb_arbiter;

   localparam int DEPTH    = 2;
   localparam int MAX_WAIT = 4;
   localparam int CNT_W    = $clog2(DEPTH + 1);

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             pipe_we_i;
   logic [4:0]       pipe_waddr_i;
   logic [31:0]      pipe_wdata_i;
   logic             ll_valid_i;
   logic             ll_ready_o;
   logic [4:0]       ll_waddr_i;
   logic [31:0]      ll_wdata_i;
   logic             rf_we_o;
   logic [4:0]       rf_waddr_o;
   logic [31:0]      rf_wdata_o;
   logic             pipe_stall_o;
   logic [31:0]      pending_mask_o;
   logic [CNT_W-1:0] fifo_count_o;

   rf_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .pipe_we_i(pipe_we_i), .pipe_waddr_i(pipe_waddr_i), .pipe_wdata_i(pipe_wdata_i),
      .ll_valid_i(ll_valid_i), .ll_ready_o(ll_ready_o),
      .ll_waddr_i(ll_waddr_i), .ll_wdata_i(ll_wdata_i),
      .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
      .pipe_stall_o(pipe_stall_o), .pending_mask_o(pending_mask_o),
      .fifo_count_o(fifo_count_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t mq[$];
   int   head_wait = 0;
   int   checks = 0;
   int   failures = 0;

   logic        obs_we, obs_stall, obs_ready;
   logic [4:0]  obs_addr;
   logic [31:0] obs_data, obs_mask, obs_count;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Evaluate the specification's rules on the current inputs, compare, then advance the model
   task automatic model_step();
      bit          preq, ready, acc, stl, byp, take_head;
      logic        e_we;
      logic [4:0]  e_a;
      logic [31:0] e_d, e_mask;
      preq  = pipe_we_i && pipe_waddr_i != 0;
      ready = mq.size() < DEPTH;
      acc   = ll_valid_i && ready;
      stl   = mq.size() > 0 && head_wait == MAX_WAIT;
      byp   = 0;
`ifdef RF_WB_BYPASS_EN
      byp   = mq.size() == 0 && !preq && acc && ll_waddr_i != 0;
`endif
      take_head = mq.size() > 0 && (stl || !preq);
      e_we = 0; e_a = 0; e_d = 0;
      if (take_head) begin
         e_we = 1; e_a = mq[0].a; e_d = mq[0].d;
      end else if (preq) begin
         e_we = 1; e_a = pipe_waddr_i; e_d = pipe_wdata_i;
      end else if (byp) begin
         e_we = 1; e_a = ll_waddr_i; e_d = ll_wdata_i;
      end
      e_mask = 0;
      foreach (mq[i]) e_mask = e_mask | (32'd1 << mq[i].a);

      obs_we = rf_we_o; obs_addr = rf_waddr_o; obs_data = rf_wdata_o;
      obs_stall = pipe_stall_o; obs_ready = ll_ready_o;
      obs_mask = pending_mask_o; obs_count = 32'(fifo_count_o);

      chk("rf_we", 32'(rf_we_o), 32'(e_we));
      chk("rf_waddr", 32'(rf_waddr_o), 32'(e_a));
      chk("rf_wdata", rf_wdata_o, e_d);
      chk("pipe_stall", 32'(pipe_stall_o), 32'(stl && preq));
      chk("ll_ready", 32'(ll_ready_o), 32'(ready));
      chk("pending_mask", pending_mask_o, e_mask);
      chk("fifo_count", 32'(fifo_count_o), 32'(mq.size()));

      if (take_head) begin
         void'(mq.pop_front());
         head_wait = 0;
      end else if (mq.size() > 0) begin
         if (head_wait < MAX_WAIT) head_wait++;
      end else begin
         head_wait = 0;
      end
      if (acc && ll_waddr_i != 0 && !byp) begin
         ent_t e;
         e.a = ll_waddr_i; e.d = ll_wdata_i;
         mq.push_back(e);
      end
   endtask

   task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld);
      pipe_we_i = pwe; pipe_waddr_i = pa; pipe_wdata_i = pd;
      ll_valid_i = lv; ll_waddr_i = la; ll_wdata_i = ld;
   endtask

   task automatic cycle(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld);
      drive(pwe, pa, pd, lv, la, ld);
      #1;
      model_step();
      @(negedge clk_i);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      logic        pwe, lv;
      logic [4:0]  pa, la;
      logic [31:0] pd, ld;

      rst_ni = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk_i);
      @(negedge clk_i);
      chk("reset_count", 32'(fifo_count_o), 0);
      chk("reset_ready", 32'(ll_ready_o), 1);
      rst_ni = 1'b1;

      // idle after reset
      cycle(0, 0, 0, 0, 0, 0);
      chk("idle_we", 32'(obs_we), 0);
      chk("idle_ready", 32'(obs_ready), 1);
      chk("idle_mask", obs_mask, 0);

      // starvation: pipe writes x5 every cycle, x7 accepted at cycle 0
      cycle(1, 5, 32'hDEADBEEF, 1, 7, 32'h1234);
      chk("starve_c0_addr", 32'(obs_addr), 5);
      for (int c = 1; c <= 4; c++) begin
         cycle(1, 5, 32'hDEADBEEF, 0, 0, 0);
         chk("starve_blocked_addr", 32'(obs_addr), 5);
         chk("starve_mask", obs_mask, 32'h80);
         chk("starve_no_stall", 32'(obs_stall), 0);
      end
      cycle(1, 5, 32'hDEADBEEF, 0, 0, 0);
      chk("starve_c5_stall", 32'(obs_stall), 1);
      chk("starve_c5_addr", 32'(obs_addr), 7);
      chk("starve_c5_data", obs_data, 32'h1234);
      cycle(1, 5, 32'hDEADBEEF, 0, 0, 0);
      chk("starve_c6_addr", 32'(obs_addr), 5);
      chk("starve_c6_stall", 32'(obs_stall), 0);
      idle(1);

      // fill while pipe busy, then drain in order
      cycle(1, 5, 32'h1, 1, 3, 32'h33);
      cycle(1, 5, 32'h2, 1, 4, 32'h44);
      cycle(1, 5, 32'h3, 1, 6, 32'h66);
      chk("full_ready", 32'(obs_ready), 0);
      chk("full_count", obs_count, 2);
      cycle(0, 0, 0, 0, 0, 0);
      chk("drain1_addr", 32'(obs_addr), 3);
      chk("drain1_data", obs_data, 32'h33);
      cycle(0, 0, 0, 0, 0, 0);
      chk("drain2_addr", 32'(obs_addr), 4);
      chk("drain2_ready", 32'(obs_ready), 1);
      idle(1);

      // pipe write to x0 lets the head through; LL result to x0 is dropped
      cycle(1, 5, 32'h9, 1, 9, 32'h55);
      cycle(1, 0, 32'hFFFF, 0, 0, 0);
      chk("x0pipe_addr", 32'(obs_addr), 9);
      chk("x0pipe_data", obs_data, 32'h55);
      cycle(0, 0, 0, 1, 0, 32'h77);
      chk("x0ll_we", 32'(obs_we), 0);
      cycle(0, 0, 0, 0, 0, 0);
      chk("x0ll_count", obs_count, 0);

      // simultaneous enqueue and dequeue at count 1
      cycle(1, 5, 32'h5, 1, 11, 32'hB);
      cycle(0, 0, 0, 1, 10, 32'hA);
      chk("swap_addr", 32'(obs_addr), 11);
      cycle(0, 0, 0, 0, 0, 0);
      chk("swap_count", obs_count, 1);
      chk("swap_mask", obs_mask, 32'h400);
      idle(1);

      // empty FIFO, idle pipe, LL x12
      cycle(0, 0, 0, 1, 12, 32'hA5A5A5A5);
`ifdef RF_WB_BYPASS_EN
      chk("byp_we", 32'(obs_we), 1);
      chk("byp_addr", 32'(obs_addr), 12);
      cycle(0, 0, 0, 0, 0, 0);
      chk("byp_count", obs_count, 0);
`else
      chk("nobyp_we", 32'(obs_we), 0);
      cycle(0, 0, 0, 0, 0, 0);
      chk("nobyp_addr", 32'(obs_addr), 12);
      chk("nobyp_data", obs_data, 32'hA5A5A5A5);
`endif
      idle(1);

      // reset in the middle of a drain with two entries buffered
      cycle(1, 5, 32'h1, 1, 20, 32'h20);
      cycle(1, 5, 32'h2, 1, 21, 32'h21);
      drive(0, 0, 0, 0, 0, 0);
      #1;
      rst_ni = 1'b0;
      #1;
      chk("midrst_count", 32'(fifo_count_o), 0);
      chk("midrst_mask", pending_mask_o, 0);
      mq.delete();
      head_wait = 0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      idle(1);

      // random traffic; a stalled pipeline request is held until it is taken
      pwe = 0; pa = 0; pd = 0;
      for (int n = 0; n < 3000; n++) begin
         if (!obs_stall) begin
            pwe = ($urandom_range(0, 99) < 60);
            pa  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            pd  = $urandom;
         end
         lv = ($urandom_range(0, 99) < 45);
         la = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
         ld = $urandom;
         cycle(pwe, pa, pd, lv, la, ld);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Arbitrates the single register-file write port between the in-order pipeline writeback (from the WB stage) and a long-latency unit (divider, or load-miss return) that delivers results out of band. The pipeline write has priority. Long-latency results are buffered in a small FIFO and drained in idle write slots. An anti-starvation counter stalls the pipeline when the buffered head has waited too long. The block sits between wb_stage and the register file, and exports a pending-destination mask for issue hazard checks.

Parameters:
DEPTH, 2, long-latency result FIFO entries; power of two, >=2
MAX_WAIT, 4, cycles the FIFO head may be blocked before pipeline stall; >=1
CNT_W, $clog2(DEPTH+1), width of fifo_count_o (derived, not overridden)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
pipe_we_i  in  1  pipeline writeback enable (reg_write && valid)
pipe_waddr_i  in  5  pipeline destination register
pipe_wdata_i  in  32  pipeline result
ll_valid_i  in  1  long-latency result valid
ll_ready_o  out  1  FIFO can accept a result
ll_waddr_i  in  5  long-latency destination register
ll_wdata_i  in  32  long-latency result
rf_we_o  out  1  register file write enable
rf_waddr_o  out  5  register file write address
rf_wdata_o  out  32  register file write data
pipe_stall_o  out  1  pipeline must hold its WB register this cycle
pending_mask_o  out  32  bit n set while any buffered entry targets xn
fifo_count_o  out  CNT_W  occupied FIFO entries

Behaviour:
- Clock is clk_i. Reset is rst_ni, asynchronous and active-low.
- Reset clears FIFO pointers, count and wait counter.
- Outputs with idle inputs after reset:
  - rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0.
  - pipe_stall_o=0, pending_mask_o=0, fifo_count_o=0.
  - ll_ready_o=1.
- Reset asserted mid-operation discards all buffered entries.
- Effective pipe request: pipe_req = pipe_we_i && pipe_waddr_i!=0. Writes to x0 never reach the port.
- Handshake: a result is accepted when ll_valid_i && ll_ready_o.
  - ll_ready_o = (count < DEPTH). It does not depend on a same-cycle dequeue, so a full FIFO does not accept.
  - Accepted results with ll_waddr_i==0 are consumed and dropped, never enqueued.
- Starvation control:
  - stall = fifo nonempty && wait_cnt==MAX_WAIT.
  - pipe_stall_o = stall && pipe_req.
- Write-port selection (combinational, same cycle):
  1. stall, or (fifo nonempty && !pipe_req): FIFO head is written and dequeued.
  2. else pipe_req: pipeline result is written.
  3. else: rf_we_o=0, address and data 0.
- When pipe_stall_o=1 the pipeline write is not performed. The caller re-presents the same request next cycle.
- Wait counter:
  - Cleared when the FIFO is empty or the head is dequeued.
  - Otherwise increments each cycle the head is blocked by pipe_req.
  - Saturates at MAX_WAIT.
- Enqueue and dequeue may occur in the same cycle. Count is unchanged when both happen.
- Pointers wrap modulo DEPTH.
- pending_mask_o is the OR of one-hot(waddr) over valid entries, registered state only (excludes this cycle's enqueue). Issue logic must block WAW/RAW on set bits. The arbiter does not reorder or check hazards.
- The FIFO drains in order. Data passes unmodified (32-bit, no width conversion).

Optional Feature:
Macro RF_WB_BYPASS_EN.
- Defined: if the FIFO is empty, pipe_req=0, and an accepted result has ll_waddr_i!=0, the result is written to the register file in the same cycle and not enqueued. Zero-cycle latency; pending_mask_o never reflects it.
- Undefined: every non-x0 accepted result is enqueued. Earliest register-file write is the next cycle.

Test Plan:
- Reset, idle inputs -> all outputs at reset values, ll_ready_o=1. Assert rst_ni low mid-drain with count=2 -> count=0 and mask=0 immediately.
- Pipe writes x5=0xDEADBEEF every cycle. LL result x7=0x1234 accepted at cycle 0 -> mask bit 7 set. Head blocked 4 cycles, then pipe_stall_o=1 and x7 written at cycle 5 (MAX_WAIT=4). Pipe x5 written the following cycle.
- Fill FIFO with x3 then x4 while pipe busy -> ll_ready_o=0, third valid not accepted. Pipe goes idle -> x3 then x4 written on consecutive cycles (order preserved), ready returns after the first dequeue.
- Pipe write to x0 with FIFO holding x9=0x55 -> x9 written that cycle. LL result to x0 accepted -> nothing written or enqueued, count unchanged.
- Simultaneous enqueue x10 and dequeue x11 at count=1 -> count stays 1, mask changes from bit 11 to bit 10.
- With RF_WB_BYPASS_EN, empty FIFO, pipe idle, LL x12=0xA5A5A5A5 -> rf_we_o=1 same cycle, count stays 0. Without the macro -> written one cycle later.
